// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width for a W-bit by W-bit unsigned multiply.
  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/add4_core.sv
// Combinational W-bit ripple-carry adder; drop-in match for the behavioural full-adder block.
module add4_core #(
  parameter int unsigned W = 4
) (
  output logic [W-1:0] s,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  logic [W:0] cy;

  always_comb begin
    s     = '0;
    cy    = '0;
    cy[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
    cout = cy[W];
  end

endmodule

// File: rtl/mul4_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial-product step per clock
// through a single shared adder, product registered on entry to DONE.
module mul4_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  output logic                   busy,
  output logic                   done,
  output logic [prod_w(W)-1:0]   p
);

  localparam int unsigned PW = prod_w(W);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned SW = 2 * W + 1;

  state_t          state, state_nxt;
  logic [W-1:0]    m, m_nxt;
  logic            c, c_nxt;
  logic [W-1:0]    h, h_nxt;
  logic [W-1:0]    l, l_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   p_nxt;
  logic            busy_nxt, done_nxt;

  logic [W-1:0]    add_b;
  logic [W-1:0]    sum;
  logic            cout;
  logic [SW-1:0]   step;

  assign add_b = l[0] ? m : '0;

  // c is the bit shifted in above cout, so it is zero after every step and at load;
  // using it as cin keeps the adder carry-in at zero.
  add4_core #(.W(W)) u_add (
    .s    (sum),
    .cout (cout),
    .a    (h),
    .b    (add_b),
    .cin  (c)
  );

  assign step = SW'({1'b0, cout, sum, l} >> 1);

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    c_nxt     = c;
    h_nxt     = h;
    l_nxt     = l;
    cnt_nxt   = cnt;
    p_nxt     = p;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          m_nxt     = a;
          l_nxt     = b;
          h_nxt     = '0;
          c_nxt     = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        c_nxt = step[SW-1];
        h_nxt = step[SW-2:W];
        l_nxt = step[W-1:0];
        if (cnt == CW'(W - 1)) begin
          p_nxt     = {h_nxt, l_nxt};
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      c     <= 1'b0;
      h     <= '0;
      l     <= '0;
      cnt   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      c     <= c_nxt;
      h     <= h_nxt;
      l     <= l_nxt;
      cnt   <= cnt_nxt;
      p     <= p_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq (W=4).
module tb_mul4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int tests;
  int fails;
  logic       mon_en;
  logic [7:0] prev_p;

  mul4_seq #(.W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle-level invariants: busy/done exclusive, p only moves with done
  always @(negedge clk) begin
    #2;
    if (rst || !mon_en) begin
      prev_p = p;
    end else begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (!done) chk("p_stable", 32'(p), 32'(prev_p));
      prev_p = p;
    end
  end

  // Start a product from IDLE and check the full latency profile
  task automatic run_one(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_k", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("nodone_run", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_kW", 32'(done), 32'd1);
    chk("busy_kW", 32'(busy), 32'd0);
    chk("p_kW", 32'(p), 32'(exp));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("p_hold", 32'(p), 32'(exp));
  endtask

  initial begin
    tests = 0; fails = 0; mon_en = 1'b0; prev_p = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_p", 32'(p), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Basic products
    run_one(4'd3, 4'd5, 8'h0F);
    run_one(4'd0, 4'd0, 8'h00);
    run_one(4'd15, 4'd15, 8'hE1);
    run_one(4'd7, 4'd14, 8'h62);

    // Start while busy is ignored
    a = 4'd9; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sb_busy_k", 32'(busy), 32'd1);
    @(negedge clk);
    chk("sb_busy_k1", 32'(busy), 32'd1);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sb_busy_k2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("sb_busy_k3", 32'(busy), 32'd1);
    chk("sb_nodone_k3", 32'(done), 32'd0);
    @(negedge clk);
    chk("sb_done_k4", 32'(done), 32'd1);
    chk("sb_p_k4", 32'(p), 32'h36);
    @(negedge clk);
    chk("sb_no_requeue_busy", 32'(busy), 32'd0);
    chk("sb_no_requeue_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("sb_idle_busy", 32'(busy), 32'd0);

    // Back-to-back with start held through DONE
    a = 4'd2; b = 4'd8; start = 1'b1;
    @(negedge clk);
    a = 4'd15; b = 4'd1;
    repeat (3) @(negedge clk);
    chk("b2b_busy_k3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("b2b_done_k4", 32'(done), 32'd1);
    chk("b2b_p_k4", 32'(p), 32'h10);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_k5", 32'(busy), 32'd1);
    chk("b2b_done_k5", 32'(done), 32'd0);
    chk("b2b_p_k5", 32'(p), 32'h10);
    repeat (3) @(negedge clk);
    chk("b2b_nodone_k8", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_done_k9", 32'(done), 32'd1);
    chk("b2b_p_k9", 32'(p), 32'h0F);
    @(negedge clk);

    // Reset mid-operation
    a = 4'd12; b = 4'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_p", 32'(p), 32'h00);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(done), 32'd0);
      chk("mrst_no_busy", 32'(busy), 32'd0);
    end
    run_one(4'd4, 4'd4, 8'h10);

    // Exhaustive back-to-back sweep
    a = 4'd0; b = 4'd0; start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ai, bi;
      logic [7:0] exp;
      ai  = 4'(i >> 4);
      bi  = 4'(i);
      exp = 8'(ai * bi);
      @(negedge clk);
      chk("sw_busy", 32'(busy), 32'd1);
      if (i == 255) begin
        start = 1'b0;
      end else begin
        a = 4'((i + 1) >> 4);
        b = 4'(i + 1);
      end
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("sw_done", 32'(done), 32'd1);
      chk("sw_p", 32'(p), 32'(exp));
    end
    @(negedge clk);
    chk("sw_end_idle", 32'(busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
